// File: rtl/des_keysched_pkg.sv
// Shared types, permutation tables and rotate helpers for the DES key schedule.
package des_keysched_pkg;

  localparam int unsigned KEY_W    = 64;
  localparam int unsigned CD_W     = 56;
  localparam int unsigned HALF_W   = 28;
  localparam int unsigned SUBKEY_W = 48;
  localparam int unsigned ROUND_W  = 4;
  localparam int unsigned SHIFT_W  = 2;
  localparam int unsigned IDX_W    = 6;

  typedef logic [0:HALF_W-1]   half_key_t;
  typedef logic [0:SUBKEY_W-1] subkey_t;
  typedef logic [0:CD_W-1]     cd_key_t;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  // PC-1, zero-based MSB-first positions into the 64-bit key; parity bits never selected.
  localparam logic [IDX_W-1:0] PC1_TABLE [CD_W] = '{
    6'd56, 6'd48, 6'd40, 6'd32, 6'd24, 6'd16, 6'd8,
    6'd0,  6'd57, 6'd49, 6'd41, 6'd33, 6'd25, 6'd17,
    6'd9,  6'd1,  6'd58, 6'd50, 6'd42, 6'd34, 6'd26,
    6'd18, 6'd10, 6'd2,  6'd59, 6'd51, 6'd43, 6'd35,
    6'd62, 6'd54, 6'd46, 6'd38, 6'd30, 6'd22, 6'd14,
    6'd6,  6'd61, 6'd53, 6'd45, 6'd37, 6'd29, 6'd21,
    6'd13, 6'd5,  6'd60, 6'd52, 6'd44, 6'd36, 6'd28,
    6'd20, 6'd12, 6'd4,  6'd27, 6'd19, 6'd11, 6'd3
  };

  // PC-2, zero-based MSB-first positions into C||D.
  localparam logic [IDX_W-1:0] PC2_TABLE [SUBKEY_W] = '{
    6'd13, 6'd16, 6'd10, 6'd23, 6'd0,  6'd4,
    6'd2,  6'd27, 6'd14, 6'd5,  6'd20, 6'd9,
    6'd22, 6'd18, 6'd11, 6'd3,  6'd25, 6'd7,
    6'd15, 6'd6,  6'd26, 6'd19, 6'd12, 6'd1,
    6'd40, 6'd51, 6'd30, 6'd36, 6'd46, 6'd54,
    6'd29, 6'd39, 6'd50, 6'd44, 6'd32, 6'd47,
    6'd43, 6'd48, 6'd38, 6'd55, 6'd33, 6'd52,
    6'd45, 6'd41, 6'd49, 6'd35, 6'd28, 6'd31
  };

  // Rotation applied before issuing round i; entry 0 is applied at load time.
  localparam logic [SHIFT_W-1:0] ENC_SHIFT [16] = '{
    2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
    2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
  };

  // Decrypt walks the encrypt rotations backwards; K16 needs no shift from C0/D0.
  localparam logic [SHIFT_W-1:0] DEC_SHIFT [16] = '{
    2'd0, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
    2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
  };

  // PC-1: select the 56 key bits that form C0||D0.
  function automatic cd_key_t pc1(input logic [0:KEY_W-1] key);
    cd_key_t cd;
    cd = '0;
    for (int unsigned i = 0; i < CD_W; i++) begin
      cd[IDX_W'(i)] = key[PC1_TABLE[IDX_W'(i)]];
    end
    return cd;
  endfunction

  // Rotate a half key towards bit 0 by 0..2 positions.
  function automatic half_key_t rotl(input half_key_t x, input logic [SHIFT_W-1:0] n);
    half_key_t r;
    case (n)
      2'd1:    r = {x[1:27], x[0]};
      2'd2:    r = {x[2:27], x[0:1]};
      default: r = x;
    endcase
    return r;
  endfunction

  // Rotate a half key away from bit 0 by 0..2 positions.
  function automatic half_key_t rotr(input half_key_t x, input logic [SHIFT_W-1:0] n);
    half_key_t r;
    case (n)
      2'd1:    r = {x[27], x[0:26]};
      2'd2:    r = {x[26:27], x[0:25]};
      default: r = x;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/des_key_schedule_pc2.sv
// Combinational PC-2 compression of C||D into a 48-bit round subkey.
module des_pc2
  import des_keysched_pkg::*;
(
  input  logic [0:CD_W-1]     cd_i,
  output logic [0:SUBKEY_W-1] subkey_o
);

  // Pure bit selection; no logic beyond wiring.
  always_comb begin
    subkey_o = '0;
    for (int unsigned i = 0; i < SUBKEY_W; i++) begin
      subkey_o[IDX_W'(i)] = cd_i[PC2_TABLE[IDX_W'(i)]];
    end
  end

endmodule

// File: rtl/des_key_schedule.sv
// Iterative DES subkey generator: one subkey per valid/ready handshake, encrypt or decrypt order.
module des_key_schedule
  import des_keysched_pkg::*;
#(
  parameter int unsigned NUM_ROUNDS = 16
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic [0:KEY_W-1]    key_in,
  input  logic                key_load,
  input  logic                decrypt,
  output logic                busy,
  output logic [0:SUBKEY_W-1] round_key,
  output logic                key_valid,
  input  logic                key_ready,
  output logic [ROUND_W-1:0]  round_num,
  output logic                last_round,
  output logic                done
);

  localparam logic [ROUND_W-1:0] LAST_IDX = ROUND_W'(NUM_ROUNDS - 1);

  state_e               state_q, state_d;
  half_key_t            c_q, c_d;
  half_key_t            d_q, d_d;
  logic [ROUND_W-1:0]   round_q, round_d;
  logic                 dir_q, dir_d;
  logic                 done_q, done_d;

  cd_key_t              cd_load;
  half_key_t            c0, d0;
  logic [ROUND_W-1:0]   next_idx;
  logic [SHIFT_W-1:0]   adv_shift;
  logic                 running;
  logic                 accept;
  logic                 at_last;
  subkey_t              pc2_out;

  // Load-time permutation and per-round handshake decode.
  always_comb begin
    cd_load   = pc1(key_in);
    c0        = cd_load[0:HALF_W-1];
    d0        = cd_load[HALF_W:CD_W-1];
    running   = (state_q == RUN);
    accept    = running & key_ready;
    at_last   = (round_q == LAST_IDX);
    next_idx  = round_q + ROUND_W'(1);
    adv_shift = dir_q ? DEC_SHIFT[next_idx] : ENC_SHIFT[next_idx];
  end

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    c_d     = c_q;
    d_d     = d_q;
    round_d = round_q;
    dir_d   = dir_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (key_load) begin
          state_d = RUN;
          dir_d   = decrypt;
          round_d = '0;
          if (decrypt) begin
            c_d = rotr(c0, DEC_SHIFT[0]);
            d_d = rotr(d0, DEC_SHIFT[0]);
          end else begin
            c_d = rotl(c0, ENC_SHIFT[0]);
            d_d = rotl(d0, ENC_SHIFT[0]);
          end
        end
      end
      RUN: begin
        if (accept) begin
          if (at_last) begin
            state_d = IDLE;
            round_d = '0;
            done_d  = 1'b1;
          end else begin
            round_d = next_idx;
            if (dir_q) begin
              c_d = rotr(c_q, adv_shift);
              d_d = rotr(d_q, adv_shift);
            end else begin
              c_d = rotl(c_q, adv_shift);
              d_d = rotl(d_q, adv_shift);
            end
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, key halves, round counter, direction and done pulse.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= IDLE;
      c_q     <= '0;
      d_q     <= '0;
      round_q <= '0;
      dir_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      c_q     <= c_d;
      d_q     <= d_d;
      round_q <= round_d;
      dir_q   <= dir_d;
      done_q  <= done_d;
    end
  end

  des_pc2 u_pc2 (
    .cd_i     ({c_q, d_q}),
    .subkey_o (pc2_out)
  );

  // Outputs derive from registers only; the subkey is forced to zero while idle.
  always_comb begin
    busy       = running;
    key_valid  = running;
    round_key  = running ? pc2_out : '0;
    round_num  = round_q;
    last_round = running & at_last;
    done       = done_q;
  end

endmodule

// File: tb/tb_des_key_schedule.sv
// Directed self-checking bench for des_key_schedule using the classic 133457799BBCDFF1 key.
module tb_des_key_schedule;

  localparam logic [63:0] KEY_A = 64'h133457799BBCDFF1;
  localparam logic [63:0] KEY_P = 64'h123456789ABCDEF0;
  localparam logic [63:0] KEY_X = 64'h0E329232EA6D0D73;

  // K1..K16 for KEY_A.
  localparam logic [47:0] KS [16] = '{
    48'h1B02EFFC7072, 48'h79AED9DBC9E5, 48'h55FC8A42CF99, 48'h72ADD6DB351D,
    48'h7CEC07EB53A8, 48'h63A53E507B2F, 48'hEC84B7F618BC, 48'hF78A3AC13BFB,
    48'hE0DBEBEDE781, 48'hB1F347BA464F, 48'h215FD3DED386, 48'h7571F59467E9,
    48'h97C5D1FABA41, 48'h5F43B7F2E73A, 48'hBF918D3D3F0A, 48'hCB3D8B0E17F5
  };

  logic        clk = 1'b0;
  logic        n_rst;
  logic [0:63] key_in;
  logic        key_load;
  logic        decrypt;
  logic        busy;
  logic [0:47] round_key;
  logic        key_valid;
  logic        key_ready;
  logic [3:0]  round_num;
  logic        last_round;
  logic        done;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  des_key_schedule #(.NUM_ROUNDS(16)) dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .key_in     (key_in),
    .key_load   (key_load),
    .decrypt    (decrypt),
    .busy       (busy),
    .round_key  (round_key),
    .key_valid  (key_valid),
    .key_ready  (key_ready),
    .round_num  (round_num),
    .last_round (last_round),
    .done       (done)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present a key for one cycle, then scramble the load-time inputs.
  task automatic load_key(input logic [63:0] k, input logic dec);
    key_in   = k;
    decrypt  = dec;
    key_load = 1'b1;
    step();
    key_load = 1'b0;
    key_in   = KEY_X;
    decrypt  = ~dec;
  endtask

  // Walk all 16 subkeys; optional 5-cycle stall and ignored reload at given rounds.
  task automatic run_sched(input logic dec, input int stall_at, input int inject_at);
    for (int r = 0; r < 16; r++) begin
      int idx;
      idx = dec ? (15 - r) : r;
      check("round_key", 64'(round_key), 64'(KS[4'(idx)]));
      check("round_num", 64'(round_num), 64'(r));
      check("key_valid", 64'(key_valid), 64'(1));
      check("last_round", 64'(last_round), 64'(r == 15));
      if (r == stall_at) begin
        key_ready = 1'b0;
        repeat (5) begin
          step();
          check("stall_key", 64'(round_key), 64'(KS[4'(idx)]));
          check("stall_num", 64'(round_num), 64'(r));
        end
        key_ready = 1'b1;
      end
      if (r == inject_at) begin
        key_in   = KEY_X;
        decrypt  = ~dec;
        key_load = 1'b1;
      end
      step();
      key_load = 1'b0;
      if (r == inject_at) check("busy_after_reload", 64'(busy), 64'(1));
    end
  endtask

  task automatic check_done();
    check("done_pulse", 64'(done), 64'(1));
    check("idle_valid", 64'(key_valid), 64'(0));
    check("idle_key", 64'(round_key), 64'(0));
    check("idle_busy", 64'(busy), 64'(0));
  endtask

  initial begin
    n_rst     = 1'b0;
    key_in    = '0;
    key_load  = 1'b0;
    decrypt   = 1'b0;
    key_ready = 1'b1;
    step();
    step();
    check("rst_valid", 64'(key_valid), 64'(0));
    check("rst_key", 64'(round_key), 64'(0));
    check("rst_num", 64'(round_num), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_last", 64'(last_round), 64'(0));
    n_rst = 1'b1;
    step();

    // Encrypt order.
    load_key(KEY_A, 1'b0);
    run_sched(1'b0, -1, -1);
    check_done();
    step();
    check("done_one_cycle", 64'(done), 64'(0));
    check("post_key", 64'(round_key), 64'(0));

    // Decrypt order is the encrypt sequence reversed.
    load_key(KEY_A, 1'b1);
    run_sched(1'b1, -1, -1);
    check_done();
    step();

    // Backpressure at round 3, ignored reload at round 7.
    load_key(KEY_A, 1'b0);
    run_sched(1'b0, 3, 7);
    check_done();
    step();

    // Asynchronous reset in the middle of a schedule.
    load_key(KEY_A, 1'b0);
    for (int r = 0; r < 10; r++) begin
      check("pre_rst_key", 64'(round_key), 64'(KS[4'(r)]));
      step();
    end
    check("pre_rst_num", 64'(round_num), 64'(10));
    n_rst = 1'b0;
    #1;
    check("midrst_valid", 64'(key_valid), 64'(0));
    check("midrst_key", 64'(round_key), 64'(0));
    check("midrst_num", 64'(round_num), 64'(0));
    check("midrst_done", 64'(done), 64'(0));
    step();
    check("midrst_done_hold", 64'(done), 64'(0));
    n_rst = 1'b1;
    step();
    check("postrst_done", 64'(done), 64'(0));
    load_key(KEY_A, 1'b0);
    run_sched(1'b0, -1, -1);
    check_done();
    step();

    // Parity bits ignored; then a back-to-back load in the done cycle.
    load_key(KEY_P, 1'b0);
    run_sched(1'b0, -1, -1);
    check_done();
    key_in   = KEY_A;
    decrypt  = 1'b1;
    key_load = 1'b1;
    step();
    key_load = 1'b0;
    check("b2b_valid", 64'(key_valid), 64'(1));
    run_sched(1'b1, -1, -1);
    check_done();
    step();
    check("final_done", 64'(done), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
